// File: rtl/shape_renderer_if.sv
// Draw handshake and pixel bus between the game sequencer (master) and a shape renderer (slave).
interface shape_renderer_if #(
    parameter int COORD_W = 11
);
    logic               draw_start;
    logic [COORD_W-1:0] origin_x;
    logic [COORD_W-1:0] origin_y;
    logic [2:0]         colour_in;
    logic               draw_done;
    logic [COORD_W-1:0] out_x;
    logic [COORD_W-1:0] out_y;
    logic [2:0]         out_colour;
    logic               plot;

    modport master (
        output draw_start, origin_x, origin_y, colour_in,
        input  draw_done, out_x, out_y, out_colour, plot
    );

    modport slave (
        input  draw_start, origin_x, origin_y, colour_in,
        output draw_done, out_x, out_y, out_colour, plot
    );
endinterface

// File: rtl/shape_renderer.sv
// Scans a W x H rectangle one pixel per clock on a four-phase draw_start/draw_done handshake.
// Optional outline mode: define SHAPE_RENDERER_FRAME_EN to plot only the border pixels.
module shape_renderer #(
    parameter int W       = 8,
    parameter int H       = 8,
    parameter int COORD_W = 11
) (
    input  logic            clock,
    input  logic            resetn,
    shape_renderer_if.slave bus
);
    localparam int CX_W = (W > 1) ? $clog2(W) : 1;
    localparam int CY_W = (H > 1) ? $clog2(H) : 1;
    localparam logic [CX_W-1:0] CX_LAST = CX_W'(W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CX_W-1:0]    cx;
    logic [CY_W-1:0]    cy;
    logic [COORD_W-1:0] lat_x, lat_y;
    logic [2:0]         lat_colour;
    logic               last_px;

    assign last_px = (cx == CX_LAST) && (cy == CY_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (bus.draw_start) state_nxt = DRAW;
            DRAW: begin
                // Withdrawing the request aborts, even on the final pixel.
                if (!bus.draw_start) state_nxt = IDLE;
                else if (last_px)    state_nxt = DONE;
            end
            DONE: if (!bus.draw_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Counters freeze on the last pixel so outputs hold steady while DONE is held.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cx         <= '0;
            cy         <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_colour <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.draw_start) begin
                        lat_x      <= bus.origin_x;
                        lat_y      <= bus.origin_y;
                        lat_colour <= bus.colour_in;
                        cx         <= '0;
                        cy         <= '0;
                    end
                end
                DRAW: begin
                    if (bus.draw_start && !last_px) begin
                        if (cx == CX_LAST) begin
                            cx <= '0;
                            cy <= cy + 1'b1;
                        end else begin
                            cx <= cx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.out_x      = lat_x + COORD_W'(cx);
        bus.out_y      = lat_y + COORD_W'(cy);
        bus.out_colour = lat_colour;
        bus.draw_done  = (state == DONE);
`ifdef SHAPE_RENDERER_FRAME_EN
        bus.plot = (state == DRAW) &&
                   ((cx == '0) || (cx == CX_LAST) || (cy == '0) || (cy == CY_LAST));
`else
        bus.plot = (state == DRAW);
`endif
    end
endmodule

// File: tb/tb_shape_renderer.sv
// Randomised and directed bench for shape_renderer against a pixel-index reference model.
module tb_shape_renderer;
    localparam int W       = 4;
    localparam int H       = 3;
    localparam int COORD_W = 11;
    localparam int NPIX    = W * H;
    localparam int MODV    = 1 << COORD_W;

    logic clock;
    logic resetn;
    int   n_total;
    int   n_bad;

    shape_renderer_if #(.COORD_W(COORD_W)) bus ();

    shape_renderer #(.W(W), .H(H), .COORD_W(COORD_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected plot strobe for the k-th scanned pixel.
    function automatic logic exp_plot(input int k);
        int px, py;
        px = k % W;
        py = k / W;
`ifdef SHAPE_RENDERER_FRAME_EN
        return (px == 0) || (px == W - 1) || (py == 0) || (py == H - 1);
`else
        return (px >= 0) && (py >= 0);
`endif
    endfunction

    // Called just after a falling edge; raises draw_start, keeps it high for n_high edges, then drops it.
    task automatic run_draw(input int ox, input int oy, input int col, input int n_high);
        bus.origin_x   = COORD_W'(ox);
        bus.origin_y   = COORD_W'(oy);
        bus.colour_in  = 3'(col);
        bus.draw_start = 1'b1;
        for (int c = 1; c <= n_high; c++) begin
            @(negedge clock);
            if (c <= NPIX) begin
                check("x",      bus.out_x,      (ox + (c - 1) % W) % MODV);
                check("y",      bus.out_y,      (oy + (c - 1) / W) % MODV);
                check("plot",   bus.plot,       exp_plot(c - 1));
                check("done",   bus.draw_done,  0);
            end else begin
                check("hold_plot", bus.plot,      0);
                check("hold_done", bus.draw_done, 1);
            end
            check("colour", bus.out_colour, col);
            bus.origin_x  = COORD_W'($urandom);
            bus.origin_y  = COORD_W'($urandom);
            bus.colour_in = 3'($urandom);
        end
        bus.draw_start = 1'b0;
        @(negedge clock);
        check("drop_done",   bus.draw_done,  0);
        check("drop_plot",   bus.plot,       0);
        check("drop_colour", bus.out_colour, col);
    endtask

    initial begin
        n_total        = 0;
        n_bad          = 0;
        resetn         = 1'b0;
        bus.draw_start = 1'b0;
        bus.origin_x   = '0;
        bus.origin_y   = '0;
        bus.colour_in  = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_x",      bus.out_x,      0);
        check("rst_y",      bus.out_y,      0);
        check("rst_colour", bus.out_colour, 0);
        check("rst_plot",   bus.plot,       0);
        check("rst_done",   bus.draw_done,  0);
        resetn = 1'b1;

        // Full draw held six cycles past done, then immediate re-request.
        run_draw(10, 20, 5, NPIX + 1 + 6);
        run_draw(30, 40, 2, NPIX + 1);
        // Abort after pixel 3, then restart from a new origin.
        run_draw(10, 20, 7, 4);
        run_draw(50, 60, 6, NPIX + 2);
        // Abort on the very last pixel: no done.
        run_draw(5, 5, 1, NPIX);
        // Coordinate wrap in x and in y.
        run_draw(2046, 100, 3, NPIX + 1);
        run_draw(700, 2046, 4, NPIX + 1);

        // Asynchronous reset in the middle of a draw.
        bus.origin_x   = COORD_W'(200);
        bus.origin_y   = COORD_W'(300);
        bus.colour_in  = 3'd7;
        bus.draw_start = 1'b1;
        repeat (3) @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check("arst_x",      bus.out_x,      0);
        check("arst_y",      bus.out_y,      0);
        check("arst_colour", bus.out_colour, 0);
        check("arst_plot",   bus.plot,       0);
        check("arst_done",   bus.draw_done,  0);
        @(negedge clock);
        resetn = 1'b1;
        run_draw(200, 300, 7, NPIX + 3);

        for (int i = 0; i < 25; i++) begin
            int ox, oy, col, n_high;
            ox  = int'($urandom_range(0, MODV - 1));
            oy  = int'($urandom_range(0, MODV - 1));
            col = int'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) n_high = int'($urandom_range(1, NPIX));
            else                           n_high = NPIX + 1 + int'($urandom_range(0, 5));
            run_draw(ox, oy, col, n_high);
            if ($urandom_range(0, 1) == 1) @(negedge clock);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
